attn_seq_ctrl: RTL and testbench

Top-level sequencer for one self-attention pass. Launches and retires the three attention datapath stages in order: score (QK^T), softmax, and attention-times-V multiply. Every stage uses the level start/sticky done handshake. Adds a per-stage watchdog, abort, a softmax bypass, and pass statistics, and sits between the host command interface and the stage blocks.

---
 rtl/attn_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_attn_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_seq_ctrl.sv
// Self-attention pass sequencer: runs score, softmax and attention-times-V stages in order
// over a level start / sticky done handshake, with per-stage watchdog, abort and pass statistics.
module attn_seq_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   input  logic                 abort,
   input  logic                 skip_softmax,
   output logic                 qk_start,
   input  logic                 qk_done,
   output logic                 sm_start,
   input  logic                 sm_done,
   output logic                 av_start,
   input  logic                 av_done,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           err_code,
   output logic [1:0]           err_stage,
   output logic [CNT_WIDTH-1:0] last_pass_cycles,
   output logic [15:0]          pass_count,
   output logic [2:0]           debug_state
);
   localparam int unsigned         WD_WIDTH    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_WIDTH-1:0] WD_LAST     = WD_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]          ERR_TIMEOUT = 2'd1;
   localparam logic [1:0]          ERR_ABORT   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_QK_RUN = 3'd1,
      S_QK_REL = 3'd2,
      S_SM_RUN = 3'd3,
      S_SM_REL = 3'd4,
      S_AV_RUN = 3'd5,
      S_AV_REL = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   state_t               state, next_state, adv_state;
   logic                 skip_q;
   logic [WD_WIDTH-1:0]  wd;
   logic [CNT_WIDTH-1:0] cyc, cyc_inc;
   logic [15:0]          pass_cnt_q;
   logic                 launch, clear_fault, finish, to_fault;
   logic                 stage_done, exit_cond;
   logic [1:0]           fault_code, cur_stage;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
      next_state  = state;
      adv_state   = S_IDLE;
      launch      = 1'b0;
      clear_fault = 1'b0;
      finish      = 1'b0;
      to_fault    = 1'b0;
      fault_code  = 2'd0;
      cur_stage   = 2'd0;
      stage_done  = 1'b0;
      exit_cond   = 1'b0;

      unique case (state)
         S_QK_RUN, S_QK_REL: begin cur_stage = 2'd0; stage_done = qk_done; end
         S_SM_RUN, S_SM_REL: begin cur_stage = 2'd1; stage_done = sm_done; end
         S_AV_RUN, S_AV_REL: begin cur_stage = 2'd2; stage_done = av_done; end
         default: ;
      endcase

      unique case (state)
         S_QK_RUN: adv_state = S_QK_REL;
         S_QK_REL: adv_state = skip_q ? S_AV_RUN : S_SM_RUN;
         S_SM_RUN: adv_state = S_SM_REL;
         S_SM_REL: adv_state = S_AV_RUN;
         S_AV_RUN: adv_state = S_AV_REL;
         default:  adv_state = S_IDLE;
      endcase

      // RUN states wait for done to rise, REL states wait for it to drop
      exit_cond = (state == S_QK_RUN || state == S_SM_RUN || state == S_AV_RUN) ? stage_done : !stage_done;

      case (state)
         S_IDLE: begin
            if (go) begin
               launch     = 1'b1;
               next_state = S_QK_RUN;
            end
         end
         S_FAULT: begin
            if (go) begin
               clear_fault = 1'b1;
               next_state  = S_IDLE;
            end
         end
         default: begin
            if (abort) begin
               to_fault   = 1'b1;
               fault_code = ERR_ABORT;
            end else if (exit_cond) begin
               next_state = adv_state;
               finish     = (state == S_AV_REL);
            end else if (wd == WD_LAST) begin
               to_fault   = 1'b1;
               fault_code = ERR_TIMEOUT;
            end
            if (to_fault) next_state = S_FAULT;
         end
      endcase
   end

   assign cyc_inc = (cyc == '1) ? cyc : cyc + 1'b1;

   // NOTE: all state updates are non-blocking so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         done             <= 1'b0;
         skip_q           <= 1'b0;
         wd               <= '0;
         cyc              <= '0;
         last_pass_cycles <= '0;
         pass_cnt_q       <= '0;
         err_code         <= '0;
         err_stage        <= '0;
      end else begin
         state <= next_state;
         done  <= finish;
         if (launch) skip_q <= skip_softmax;
         // watchdog restarts on every state change and idles at zero outside RUN/REL
         wd <= (busy && next_state == state) ? wd + 1'b1 : '0;
         if (launch)    cyc <= '0;
         else if (busy) cyc <= cyc_inc;
         if (finish) begin
            last_pass_cycles <= cyc_inc;
            pass_cnt_q       <= pass_cnt_q + 1'b1;
         end
         if (to_fault) begin
            err_code  <= fault_code;
            err_stage <= cur_stage;
         end else if (clear_fault) begin
            err_code  <= '0;
            err_stage <= '0;
         end
      end
   end

   assign qk_start    = (state == S_QK_RUN);
   assign sm_start    = (state == S_SM_RUN);
   assign av_start    = (state == S_AV_RUN);
   assign busy        = (state != S_IDLE) && (state != S_FAULT);
   assign error       = (state == S_FAULT);
   assign pass_count  = pass_cnt_q;
   assign debug_state = state;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Bench for attn_seq_ctrl: stage stubs with randomized latencies; expected timing and
// statistics come from per-stage cost arithmetic (RUN = rise+1, REL = fall+1 cycles).
module tb_attn_seq_ctrl;
   localparam int T = 16;

   logic        clk, rst, go, abort, skip_softmax;
   logic        qk_start, sm_start, av_start, qk_done, sm_done, av_done;
   logic        busy, done, error;
   logic [1:0]  err_code, err_stage;
   logic [31:0] last_pass_cycles;
   logic [15:0] pass_count;
   logic [2:0]  debug_state;

   logic [2:0]  starts, st_done;
   int          rise_lat[3];
   int          fall_lat[3];
   bit          hang[3];
   int          stub_cnt[3];

   int          n_total, n_pass;
   logic [15:0] exp_pc;

   attn_seq_ctrl #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .go(go), .abort(abort), .skip_softmax(skip_softmax),
      .qk_start(qk_start), .qk_done(qk_done),
      .sm_start(sm_start), .sm_done(sm_done),
      .av_start(av_start), .av_done(av_done),
      .busy(busy), .done(done), .error(error),
      .err_code(err_code), .err_stage(err_stage),
      .last_pass_cycles(last_pass_cycles), .pass_count(pass_count),
      .debug_state(debug_state)
   );

   assign starts  = {av_start, sm_start, qk_start};
   assign qk_done = st_done[0];
   assign sm_done = st_done[1];
   assign av_done = st_done[2];

   always #5 clk = ~clk;

   // stage stubs: done rises rise_lat cycles after start, drops fall_lat cycles after start falls
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            st_done[i]  <= 1'b0;
            stub_cnt[i] <= 0;
         end else if (starts[i] && !st_done[i]) begin
            if (hang[i]) stub_cnt[i] <= 0;
            else if (stub_cnt[i] + 1 >= rise_lat[i]) begin
               st_done[i]  <= 1'b1;
               stub_cnt[i] <= 0;
            end else stub_cnt[i] <= stub_cnt[i] + 1;
         end else if (!starts[i] && st_done[i]) begin
            if (stub_cnt[i] + 1 >= fall_lat[i]) begin
               st_done[i]  <= 1'b0;
               stub_cnt[i] <= 0;
            end else stub_cnt[i] <= stub_cnt[i] + 1;
         end else stub_cnt[i] <= 0;
      end
   end

   task automatic launch(input bit skip);
      go = 1'b1;
      skip_softmax = skip;
      @(negedge clk);
      go = 1'b0;
      skip_softmax = 1'($urandom_range(0, 1));
   endtask

   // Watches a pass from cycle 1 (go sampled at cycle 0) until done, fault or budget expiry.
   task automatic observe(input bit inject, input int budget,
                          output int t_qk, output int t_sm, output int t_av,
                          output int t_done, output int t_fault, output int n_overlap);
      t_qk = -1; t_sm = -1; t_av = -1; t_done = -1; t_fault = -1; n_overlap = 0;
      for (int k = 1; k <= budget; k++) begin
         if (qk_start && t_qk < 0) t_qk = k;
         if (sm_start && t_sm < 0) t_sm = k;
         if (av_start && t_av < 0) t_av = k;
         if ($countones(starts) > 1) n_overlap++;
         if (done) begin t_done = k; break; end
         if (error) begin t_fault = k; break; end
         go = inject && busy && ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      go = 1'b0;
   endtask

   task automatic test_pass(input string name, input bit skip, input bit inject);
      int c[3];
      int total, e_sm, e_av, t_qk, t_sm, t_av, t_done, t_fault, n_ovl, extra;
      for (int i = 0; i < 3; i++) c[i] = rise_lat[i] + fall_lat[i] + 2;
      total = c[0] + (skip ? 0 : c[1]) + c[2];
      e_sm  = skip ? -1 : 1 + c[0];
      e_av  = 1 + c[0] + (skip ? 0 : c[1]);
      exp_pc = exp_pc + 16'd1;
      launch(skip);
      observe(inject, total + 20, t_qk, t_sm, t_av, t_done, t_fault, n_ovl);
      n_total++; if (t_qk !== 1) $display("FAIL %s qk_start_cycle: got %0d want 1", name, t_qk); else n_pass++;
      n_total++; if (t_sm !== e_sm) $display("FAIL %s sm_start_cycle: got %0d want %0d", name, t_sm, e_sm); else n_pass++;
      n_total++; if (t_av !== e_av) $display("FAIL %s av_start_cycle: got %0d want %0d", name, t_av, e_av); else n_pass++;
      n_total++; if (t_done !== 1 + total) $display("FAIL %s done_cycle: got %0d want %0d", name, t_done, 1 + total); else n_pass++;
      n_total++; if (n_ovl !== 0) $display("FAIL %s start_overlap: got %0d want 0", name, n_ovl); else n_pass++;
      n_total++; if (last_pass_cycles !== 32'(total)) $display("FAIL %s last_pass_cycles: got %0d want %0d", name, last_pass_cycles, total); else n_pass++;
      n_total++; if (pass_count !== exp_pc) $display("FAIL %s pass_count: got %0d want %0d", name, pass_count, exp_pc); else n_pass++;
      extra = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      n_total++; if (extra !== 0) $display("FAIL %s post_pass_activity: got %0d want 0", name, extra); else n_pass++;
   endtask

   task automatic clear_fault(input string name);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n_total++;
      if ({error, busy, err_code, err_stage, debug_state} !== 9'd0)
         $display("FAIL %s fault_clear: got err=%b busy=%b code=%0d stage=%0d st=%0d want all 0", name, error, busy, err_code, err_stage, debug_state);
      else n_pass++;
      repeat (2) @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL %s no_launch_on_clear: got busy=%b want 0", name, busy); else n_pass++;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++;
      if ({qk_start, sm_start, av_start, busy, done, error, err_code, err_stage, debug_state} !== 13'd0)
         $display("FAIL reset_ctrl: got %b want 0", {qk_start, sm_start, av_start, busy, done, error, err_code, err_stage, debug_state});
      else n_pass++;
      n_total++;
      if ({last_pass_cycles, pass_count} !== 48'd0)
         $display("FAIL reset_stats: got last=%0d count=%0d want 0/0", last_pass_cycles, pass_count);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (debug_state !== 3'd0) $display("FAIL reset_idle: got %0d want 0", debug_state); else n_pass++;
   endtask

   task automatic test_random_passes();
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 3; i++) begin
            rise_lat[i] = $urandom_range(1, 5);
            fall_lat[i] = $urandom_range(1, 5);
         end
         test_pass("random", 1'($urandom_range(0, 1)), 1'b1);
      end
      for (int i = 0; i < 3; i++) begin rise_lat[i] = 1; fall_lat[i] = 1; end
   endtask

   task automatic test_watchdog();
      int t_qk, t_sm, t_av, t_done, t_fault, n_ovl;
      rise_lat[0] = T - 1;
      test_pass("wd_edge", 1'b0, 1'b0);
      rise_lat[0] = T;
      launch(1'b0);
      observe(1'b0, 60, t_qk, t_sm, t_av, t_done, t_fault, n_ovl);
      n_total++; if (t_fault !== 1 + T) $display("FAIL wd_qk fault_cycle: got %0d want %0d", t_fault, 1 + T); else n_pass++;
      n_total++; if ({err_code, err_stage} !== {2'd1, 2'd0}) $display("FAIL wd_qk err: got code=%0d stage=%0d want 1/0", err_code, err_stage); else n_pass++;
      rise_lat[0] = 1;
      clear_fault("wd_qk");
   endtask

   task automatic test_timeout();
      int t_qk, t_sm, t_av, t_done, t_fault, n_ovl;
      hang[1] = 1'b1;
      launch(1'b0);
      observe(1'b0, 60, t_qk, t_sm, t_av, t_done, t_fault, n_ovl);
      n_total++; if (t_sm !== 5) $display("FAIL timeout sm_start_cycle: got %0d want 5", t_sm); else n_pass++;
      n_total++; if (t_fault !== 5 + T) $display("FAIL timeout fault_cycle: got %0d want %0d", t_fault, 5 + T); else n_pass++;
      n_total++; if (t_done !== -1) $display("FAIL timeout no_done: got %0d want -1", t_done); else n_pass++;
      n_total++;
      if ({err_code, err_stage, starts, debug_state} !== {2'd1, 2'd1, 3'd0, 3'd7})
         $display("FAIL timeout fault_state: got code=%0d stage=%0d starts=%b st=%0d want 1/1/000/7", err_code, err_stage, starts, debug_state);
      else n_pass++;
      n_total++; if (pass_count !== exp_pc) $display("FAIL timeout pass_count: got %0d want %0d", pass_count, exp_pc); else n_pass++;
      hang[1] = 1'b0;
      clear_fault("timeout");
   endtask

   task automatic test_abort();
      int hit;
      rise_lat[2] = 3;
      hit = -1;
      launch(1'b0);
      for (int k = 1; k <= 40; k++) begin
         if (av_start && av_done) begin
            hit = k;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            break;
         end
         @(negedge clk);
      end
      n_total++; if (hit !== 12) $display("FAIL abort av_done_cycle: got %0d want 12", hit); else n_pass++;
      n_total++;
      if ({debug_state, error, err_code, err_stage, av_start, done} !== {3'd7, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0})
         $display("FAIL abort fault_state: got st=%0d err=%b code=%0d stage=%0d av=%b done=%b want 7/1/2/2/0/0", debug_state, error, err_code, err_stage, av_start, done);
      else n_pass++;
      n_total++; if (pass_count !== exp_pc) $display("FAIL abort pass_count: got %0d want %0d", pass_count, exp_pc); else n_pass++;
      rise_lat[2] = 1;
      clear_fault("abort");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_total++; if ({error, busy} !== 2'b00) $display("FAIL abort_idle_ignored: got err=%b busy=%b want 0/0", error, busy); else n_pass++;
   endtask

   task automatic test_reset_mid_pass();
      int t_sm;
      t_sm = -1;
      launch(1'b0);
      for (int k = 1; k <= 20; k++) begin
         if (sm_start) begin t_sm = k; break; end
         @(negedge clk);
      end
      n_total++; if (t_sm !== 5) $display("FAIL midrst sm_start_cycle: got %0d want 5", t_sm); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if ({starts, busy, done, error, err_code, err_stage, debug_state, last_pass_cycles, pass_count} !== 61'd0)
         $display("FAIL midrst outputs: got starts=%b busy=%b done=%b st=%0d last=%0d count=%0d want all 0", starts, busy, done, debug_state, last_pass_cycles, pass_count);
      else n_pass++;
      rst = 1'b0;
      exp_pc = 16'd0;
      test_pass("post_reset", 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      force dut.pass_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.pass_cnt_q;
      @(negedge clk);
      exp_pc = 16'hFFFF;
      n_total++; if (pass_count !== exp_pc) $display("FAIL wrap preset: got %0d want %0d", pass_count, exp_pc); else n_pass++;
      test_pass("wrap", 1'b1, 1'b0);
      test_pass("back_to_back", 1'b0, 1'b1);
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; go = 1'b0; abort = 1'b0; skip_softmax = 1'b0;
      n_total = 0; n_pass = 0; exp_pc = 16'd0;
      for (int i = 0; i < 3; i++) begin rise_lat[i] = 1; fall_lat[i] = 1; hang[i] = 1'b0; end
      test_reset();
      test_pass("nominal", 1'b0, 1'b0);
      test_pass("bypass", 1'b1, 1'b0);
      test_random_passes();
      test_watchdog();
      test_timeout();
      test_abort();
      test_reset_mid_pass();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
